// File: rtl/mips_input_conditioner_pkg.sv
// rtl/mips_input_conditioner_pkg.sv - shared constants and helpers for the input conditioner
package mips_input_conditioner_pkg;

   localparam int   DEFAULT_NUM_CH            = 3;
   localparam int   DEFAULT_DEBOUNCE_CYCLES   = 4;
   localparam int   DEFAULT_RESET_HOLD_CYCLES = 8;

   // Board buttons are active-low, so an untouched pin reads high.
   localparam logic DEFAULT_IDLE_BIT = 1'b1;

   // Width of a counter that must be able to hold max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mips_input_conditioner_if.sv
// rtl/mips_input_conditioner_if.sv - pin/core side bundle of the input conditioner
// Ports (master = pin/CPU side, slave = conditioner):
//   raw_in        raw asynchronous pin levels
//   soft_rst      one-cycle request to re-run the reset hold
//   clr           per-channel sticky clear strobes
//   level         debounced stable level
//   press         one-cycle pulse on stable 1->0
//   release_pulse one-cycle pulse on stable 0->1 ("release" is a reserved word)
//   sticky        latched press events
//   sys_reset     active-low stretched system reset
interface mips_input_conditioner_if #(
   parameter int NUM_CH = 3
) ();

   logic [NUM_CH-1:0] raw_in;
   logic              soft_rst;
   logic [NUM_CH-1:0] clr;
   logic [NUM_CH-1:0] level;
   logic [NUM_CH-1:0] press;
   logic [NUM_CH-1:0] release_pulse;
   logic [NUM_CH-1:0] sticky;
   logic              sys_reset;

   modport master (
      output raw_in, soft_rst, clr,
      input  level, press, release_pulse, sticky, sys_reset
   );

   modport slave (
      input  raw_in, soft_rst, clr,
      output level, press, release_pulse, sticky, sys_reset
   );

endinterface

// File: rtl/mips_input_conditioner_input_debounce_ch.sv
// rtl/mips_input_conditioner_input_debounce_ch.sv - single-channel synchroniser, debouncer, pulses and sticky flag
// Ports:
//   clk, reset      clock and active-low synchronous reset
//   raw             asynchronous pin level
//   clr             sticky clear strobe
//   level           debounced stable level
//   press/rls       one-cycle pulses on stable 1->0 / 0->1
//   sticky          latched press event
module input_debounce_ch
   import mips_input_conditioner_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic IDLE            = DEFAULT_IDLE_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic clr,
   output logic level,
   output logic press,
   output logic rls,
   output logic sticky
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          rls_q, rls_d;
   logic          sticky_q, sticky_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      level_d  = level_q;
      cnt_d    = cnt_q;

      // Any sample matching the stable level throws away the run so far.
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      press_d  = level_q & ~level_d;
      rls_d    = ~level_q & level_d;

      // A press pulse outranks a clear arriving in the same cycle.
      sticky_d = press_q | (sticky_q & ~clr);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q  <= IDLE;
         sync2_q  <= IDLE;
         level_q  <= IDLE;
         press_q  <= 1'b0;
         rls_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         level_q  <= level_d;
         press_q  <= press_d;
         rls_q    <= rls_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level  = level_q;
   assign press  = press_q;
   assign rls    = rls_q;
   assign sticky = sticky_q;

endmodule

// File: rtl/mips_input_conditioner.sv
// rtl/mips_input_conditioner.sv - button/switch conditioning and stretched system reset for the MIPS board
// Ports:
//   clk    system clock
//   reset  active-low synchronous reset
//   bus    slave side of mips_input_conditioner_if (raw_in, soft_rst, clr in;
//          level, press, release_pulse, sticky, sys_reset out)
module mips_input_conditioner
   import mips_input_conditioner_pkg::*;
#(
   parameter int                NUM_CH            = DEFAULT_NUM_CH,
   parameter int                DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int                RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES,
   parameter logic [NUM_CH-1:0] IDLE_LEVEL        = {NUM_CH{DEFAULT_IDLE_BIT}}
) (
   input  logic                    clk,
   input  logic                    reset,
   mips_input_conditioner_if.slave bus
);

   localparam int            HW        = cnt_width(RESET_HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

   logic [NUM_CH-1:0] level_w;
   logic [NUM_CH-1:0] press_w;
   logic [NUM_CH-1:0] rls_w;
   logic [NUM_CH-1:0] sticky_w;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      input_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE            (IDLE_LEVEL[i])
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .raw    (bus.raw_in[i]),
         .clr    (bus.clr[i]),
         .level  (level_w[i]),
         .press  (press_w[i]),
         .rls    (rls_w[i]),
         .sticky (sticky_w[i])
      );
   end

   assign bus.level         = level_w;
   assign bus.press         = press_w;
   assign bus.release_pulse = rls_w;
   assign bus.sticky        = sticky_w;

   // Reset stretcher: the counter saturates at HOLD_LAST and sys_reset rises
   // on the edge that finds it there, giving RESET_HOLD_CYCLES low cycles.
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          sys_reset_q, sys_reset_d;

   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      sys_reset_d = sys_reset_q;
      if (bus.soft_rst) begin
         hold_cnt_d  = '0;
         sys_reset_d = 1'b0;
      end else if (hold_cnt_q == HOLD_LAST) begin
         sys_reset_d = 1'b1;
      end else begin
         hold_cnt_d = hold_cnt_q + HW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_cnt_q  <= '0;
         sys_reset_q <= 1'b0;
      end else begin
         hold_cnt_q  <= hold_cnt_d;
         sys_reset_q <= sys_reset_d;
      end
   end

   assign bus.sys_reset = sys_reset_q;

endmodule

// File: tb/tb_mips_input_conditioner.sv
// tb/tb_mips_input_conditioner.sv - self-checking bench for mips_input_conditioner
module tb_mips_input_conditioner;

   localparam int         NUM_CH = 3;
   localparam int         DEB    = 4;
   localparam int         HOLD   = 8;
   localparam logic [2:0] IDLE   = 3'b111;

   logic clk;
   logic reset;

   mips_input_conditioner_if #(.NUM_CH(NUM_CH)) bus ();

   mips_input_conditioner #(
      .NUM_CH            (NUM_CH),
      .DEBOUNCE_CYCLES   (DEB),
      .RESET_HOLD_CYCLES (HOLD),
      .IDLE_LEVEL        (IDLE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: synchronised samples are raw values two edges old; a
   // channel's level flips once its last DEB synchronised samples all
   // disagree with it. sys_reset is high once HOLD quiet edges have passed.
   logic [2:0] sync_pipe[$];
   logic [2:0] sv_hist[$];
   logic [2:0] m_level, m_press, m_rel, m_sticky;
   int         since;

   task automatic model_edge(input logic r, input logic [2:0] raw, input logic s, input logic [2:0] c);
      logic [2:0] sv;
      logic [2:0] nl;
      bit         all_diff;
      if (!r) begin
         sync_pipe = {IDLE, IDLE};
         sv_hist   = {};
         m_level   = IDLE;
         m_press   = '0;
         m_rel     = '0;
         m_sticky  = '0;
         since     = 0;
      end else begin
         sv = sync_pipe.pop_front();
         sync_pipe.push_back(raw);
         sv_hist.push_back(sv);
         if (sv_hist.size() > DEB) void'(sv_hist.pop_front());
         nl = m_level;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sv_hist.size() == DEB) begin
               all_diff = 1'b1;
               foreach (sv_hist[j]) if (sv_hist[j][ch] == m_level[ch]) all_diff = 1'b0;
               if (all_diff) nl[ch] = ~m_level[ch];
            end
         end
         m_sticky = m_press | (m_sticky & ~c);
         m_press  = m_level & ~nl;
         m_rel    = ~m_level & nl;
         m_level  = nl;
         if (s) since = 0;
         else if (since < HOLD) since++;
      end
   endtask

   // One clock: drive inputs, let the edge happen, then compare away from it.
   task automatic cycle(input logic r, input logic [2:0] raw, input logic s, input logic [2:0] c);
      reset        = r;
      bus.raw_in   = raw;
      bus.soft_rst = s;
      bus.clr      = c;
      @(posedge clk);
      model_edge(r, raw, s, c);
      @(negedge clk);
      check_eq("level",     32'(bus.level),         32'(m_level));
      check_eq("press",     32'(bus.press),         32'(m_press));
      check_eq("release",   32'(bus.release_pulse), 32'(m_rel));
      check_eq("sticky",    32'(bus.sticky),        32'(m_sticky));
      check_eq("sys_reset", 32'(bus.sys_reset),     32'(since >= HOLD));
      check_eq("excl",      32'(bus.press & bus.release_pulse), 32'(0));
   endtask

   logic [2:0] raw_v;
   logic [2:0] clr_v;
   int         low_cnt;
   int         press_seen;

   initial begin
      reset        = 1'b0;
      bus.raw_in   = IDLE;
      bus.soft_rst = 1'b0;
      bus.clr      = '0;

      // Reset release and hold length.
      repeat (5) cycle(1'b0, IDLE, 1'b0, 3'b000);
      check_eq("rst_level",  32'(bus.level),  32'(IDLE));
      check_eq("rst_sticky", 32'(bus.sticky), 32'(0));
      low_cnt = (bus.sys_reset == 1'b0) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, IDLE, 1'b0, 3'b000);
         if (bus.sys_reset == 1'b0) low_cnt++;
      end
      check_eq("hold_len", 32'(low_cnt), 32'(HOLD));

      // Clean press on channel 0.
      press_seen = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 3'b110, 1'b0, 3'b000);
         if (bus.press[0]) press_seen++;
      end
      check_eq("press0_cnt",  32'(press_seen),    32'(1));
      check_eq("press0_lvl",  32'(bus.level[0]),  32'(0));
      check_eq("sticky0_set", 32'(bus.sticky[0]), 32'(1));

      // Glitch on channel 1 shorter than the debounce window.
      repeat (3) cycle(1'b1, 3'b100, 1'b0, 3'b000);
      repeat (8) cycle(1'b1, 3'b110, 1'b0, 3'b000);
      check_eq("glitch_lvl1", 32'(bus.level[1]), 32'(1));

      // Release ch0 with press ch2 together; clear ch2 during its press pulse.
      for (int i = 0; i < 10; i++) cycle(1'b1, 3'b011, 1'b0, {m_press[2], 2'b00});
      check_eq("race_sticky2", 32'(bus.sticky[2]), 32'(1));
      cycle(1'b1, 3'b011, 1'b0, 3'b100);
      check_eq("clr_sticky2",  32'(bus.sticky[2]), 32'(0));

      // Soft reset during an active hold restarts it.
      cycle(1'b0, 3'b011, 1'b0, 3'b000);
      repeat (2) cycle(1'b1, 3'b011, 1'b0, 3'b000);
      cycle(1'b1, 3'b011, 1'b1, 3'b000);
      low_cnt = (bus.sys_reset == 1'b0) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 3'b011, 1'b0, 3'b000);
         if (bus.sys_reset == 1'b0) low_cnt++;
      end
      check_eq("soft_hold", 32'(low_cnt), 32'(HOLD));

      // Reset in the middle of a debounce run.
      repeat (4) cycle(1'b1, 3'b000, 1'b0, 3'b000);
      cycle(1'b0, 3'b000, 1'b0, 3'b000);
      check_eq("mid_rst_lvl", 32'(bus.level), 32'(IDLE));
      repeat (3) cycle(1'b1, 3'b000, 1'b0, 3'b000);

      // Randomised traffic with slowly changing pins.
      raw_v = IDLE;
      for (int i = 0; i < 1500; i++) begin
         for (int ch = 0; ch < NUM_CH; ch++)
            if ($urandom_range(5) == 0) raw_v[ch] = ~raw_v[ch];
         clr_v = '0;
         for (int ch = 0; ch < NUM_CH; ch++)
            if ($urandom_range(3) == 0) clr_v[ch] = 1'b1;
         cycle(($urandom_range(99) != 0), raw_v, ($urandom_range(39) == 0), clr_v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
